mem_stage: RTL and testbench



---
 rtl/mem_stage.sv | 155 +++++++++++++++
 tb/tb_mem_stage.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access stage: registers the EX->MEM bus, runs one data-SRAM transaction per
// load/store, and produces the WB bus, the HI/LO bus and the forwarding buses to ID.
module mem_stage #(
  parameter int EX_TO_MEM_WD = 110,
  parameter int MEM_TO_WB_WD = 70
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [5:0]              stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [65:0]             ex_to_mem_1,
  output logic                    data_sram_req,
  output logic                    data_sram_wr,
  output logic [3:0]              data_sram_wstrb,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata,
  input  logic                    data_sram_addr_ok,
  input  logic                    data_sram_data_ok,
  input  logic [31:0]             data_sram_rdata,
  output logic                    stallreq_for_mem,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [65:0]             mem_to_wb_1,
  output logic [37:0]             mem_to_id_bus,
  output logic [65:0]             mem_to_id_2
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t                  state;
  logic [EX_TO_MEM_WD-1:0] bus_p1;
  logic [65:0]             hilo_p1;
  logic [31:0]             rdata_buf;

  logic        capture;
  logic        bubble;
  logic        in_mem_op;
  logic        unused_stall;
  logic [31:0] pc_p1;
  logic [4:0]  ld_op_p1;
  logic [2:0]  st_op_p1;
  logic        rf_we_p1;
  logic [4:0]  rf_waddr_p1;
  logic [31:0] ex_result_p1;
  logic [31:0] rt_data_p1;
  logic [31:0] rd;
  logic [31:0] load_data;
  logic [31:0] rf_wdata;
  logic        fill;

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
    logic signed [7:0] sb;
    sb = b;
    return sgn ? 32'(sb) : {24'b0, b};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
    logic signed [15:0] sh;
    sh = h;
    return sgn ? 32'(sh) : {16'b0, h};
  endfunction

  assign capture      = ~stall[3];
  assign bubble       = stall[3] & ~stall[4];
  assign in_mem_op    = (|ex_to_mem_bus[77:73]) | (|ex_to_mem_bus[72:70]);
  assign unused_stall = ^{stall[5], stall[2:0]};

  // an access completes (rdata captured) on data_ok in WAIT, or together with addr_ok in REQ
  assign fill = ((state == REQ) & data_sram_addr_ok & data_sram_data_ok) |
                ((state == WAIT) & data_sram_data_ok);

  // ---- stage p1: input register and access FSM ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_p1    <= '0;
      hilo_p1   <= '0;
      rdata_buf <= '0;
      state     <= IDLE;
    end else begin
      if (capture) begin
        bus_p1  <= ex_to_mem_bus;
        hilo_p1 <= ex_to_mem_1;
      end else if (bubble) begin
        bus_p1  <= '0;
        hilo_p1 <= '0;
      end
      if (fill) rdata_buf <= data_sram_rdata;
      if (capture) begin
        state <= in_mem_op ? REQ : IDLE;
      end else if (bubble) begin
        state <= IDLE;
      end else begin
        case (state)
          REQ:     if (data_sram_addr_ok) state <= data_sram_data_ok ? DONE : WAIT;
          WAIT:    if (data_sram_data_ok) state <= DONE;
          default: state <= state;
        endcase
      end
    end
  end

  assign pc_p1        = bus_p1[EX_TO_MEM_WD-1 -: 32];
  assign ld_op_p1     = bus_p1[77:73];
  assign st_op_p1     = bus_p1[72:70];
  assign rf_we_p1     = bus_p1[69];
  assign rf_waddr_p1  = bus_p1[68:64];
  assign ex_result_p1 = bus_p1[63:32];
  assign rt_data_p1   = bus_p1[31:0];

  // ---- stage p1 combinational: SRAM request, load alignment, output buses ----
  assign data_sram_req    = (state == REQ);
  assign data_sram_wr     = |st_op_p1;
  assign data_sram_addr   = {ex_result_p1[31:2], 2'b00};
  assign stallreq_for_mem = (state == REQ) | ((state == WAIT) & ~data_sram_data_ok);

  always_comb begin
    data_sram_wstrb = 4'b0000;
    data_sram_wdata = rt_data_p1;
    if (st_op_p1[2]) begin
      data_sram_wstrb = 4'b0001 << ex_result_p1[1:0];
      data_sram_wdata = {4{rt_data_p1[7:0]}};
    end else if (st_op_p1[1]) begin
      data_sram_wstrb = ex_result_p1[1] ? 4'b1100 : 4'b0011;
      data_sram_wdata = {2{rt_data_p1[15:0]}};
    end else if (st_op_p1[0]) begin
      data_sram_wstrb = 4'b1111;
    end
  end

  assign rd = (state == WAIT) ? data_sram_rdata : rdata_buf;

  always_comb begin
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    case (ex_result_p1[1:0])
      2'd0:    byte_sel = rd[7:0];
      2'd1:    byte_sel = rd[15:8];
      2'd2:    byte_sel = rd[23:16];
      default: byte_sel = rd[31:24];
    endcase
    half_sel = ex_result_p1[1] ? rd[31:16] : rd[15:0];
    load_data = rd;
    if (ld_op_p1[4])      load_data = ext8(byte_sel, 1'b1);
    else if (ld_op_p1[3]) load_data = ext8(byte_sel, 1'b0);
    else if (ld_op_p1[2]) load_data = ext16(half_sel, 1'b1);
    else if (ld_op_p1[1]) load_data = ext16(half_sel, 1'b0);
  end

  assign rf_wdata      = (|ld_op_p1) ? load_data : ex_result_p1;
  assign mem_to_wb_bus = {pc_p1, rf_we_p1, rf_waddr_p1, rf_wdata};
  // forwarding is suppressed while the load value is not yet final
  assign mem_to_id_bus = {rf_we_p1 & ~stallreq_for_mem, rf_waddr_p1, rf_wdata};
  assign mem_to_wb_1   = hilo_p1;
  assign mem_to_id_2   = hilo_p1;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed cases plus randomized loads/stores against a behavioural model
// of the stage, with the bench acting as ctrl and as a variable-latency data SRAM.
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   stall;
  logic [109:0] ex_to_mem_bus;
  logic [65:0]  ex_to_mem_1;
  logic         data_sram_req, data_sram_wr;
  logic [3:0]   data_sram_wstrb;
  logic [31:0]  data_sram_addr, data_sram_wdata;
  logic         data_sram_addr_ok, data_sram_data_ok;
  logic [31:0]  data_sram_rdata;
  logic         stallreq_for_mem;
  logic [69:0]  mem_to_wb_bus;
  logic [65:0]  mem_to_wb_1, mem_to_id_2;
  logic [37:0]  mem_to_id_bus;

  int total = 0;
  int bad   = 0;

  mem_stage dut (
    .clk(clk), .rst(rst), .stall(stall),
    .ex_to_mem_bus(ex_to_mem_bus), .ex_to_mem_1(ex_to_mem_1),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata), .data_sram_addr_ok(data_sram_addr_ok),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .stallreq_for_mem(stallreq_for_mem), .mem_to_wb_bus(mem_to_wb_bus),
    .mem_to_wb_1(mem_to_wb_1), .mem_to_id_bus(mem_to_id_bus), .mem_to_id_2(mem_to_id_2)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // kind: 0 alu, 1 lb, 2 lbu, 3 lh, 4 lhu, 5 lw, 6 sb, 7 sh, 8 sw
  function automatic logic [109:0] mk_bus(input int kind, input logic [31:0] pc,
      input logic we, input logic [4:0] wa, input logic [31:0] res, input logic [31:0] rt);
    logic [4:0] ld;
    logic [2:0] st;
    ld = 5'b0;
    st = 3'b0;
    if (kind >= 1 && kind <= 5) ld[5 - kind] = 1'b1;
    if (kind >= 6 && kind <= 8) st[8 - kind] = 1'b1;
    return {pc, ld, st, we, wa, res, rt};
  endfunction

  function automatic logic [31:0] load_model(input int kind, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] s;
    if (kind <= 2)      s = d >> (8 * a[1:0]);
    else if (kind <= 4) s = d >> (16 * a[1]);
    else                s = d;
    case (kind)
      1:       return {{24{s[7]}}, s[7:0]};
      2:       return {24'b0, s[7:0]};
      3:       return {{16{s[15]}}, s[15:0]};
      4:       return {16'b0, s[15:0]};
      default: return d;
    endcase
  endfunction

  task automatic run_txn(input int kind, input logic [31:0] pc, input logic we, input logic [4:0] wa,
      input logic [31:0] res, input logic [31:0] rt, input logic [31:0] rdv, input logic [65:0] hl,
      input int ad, input int dd, input int hold);
    logic [31:0] exp_wd, exp_wdata;
    logic [3:0]  exp_strb;
    logic [69:0] exp_wb;
    int last;
    bit is_ld, is_st;
    is_ld = (kind >= 1 && kind <= 5);
    is_st = (kind >= 6);
    exp_wd = is_ld ? load_model(kind, res, rdv) : res;
    exp_wb = {pc, we, wa, exp_wd};
    exp_strb = 4'b0;
    exp_wdata = rt;
    if (kind == 6) begin exp_strb[res[1:0]] = 1'b1; exp_wdata = {4{rt[7:0]}}; end
    if (kind == 7) begin exp_strb = res[1] ? 4'b1100 : 4'b0011; exp_wdata = {2{rt[15:0]}}; end
    if (kind == 8) exp_strb = 4'b1111;

    @(negedge clk);
    ex_to_mem_bus = mk_bus(kind, pc, we, wa, res, rt);
    ex_to_mem_1 = hl;
    stall = 6'b0;
    data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b0;
    @(posedge clk); #1;
    if (!(is_ld || is_st)) begin
      #1;
      chk("alu_wb_bus", mem_to_wb_bus, exp_wb);
      chk("alu_id_bus", mem_to_id_bus, {we, wa, res});
      chk("alu_req", data_sram_req, 1'b0);
      chk("alu_stallreq", stallreq_for_mem, 1'b0);
      chk("alu_hilo", {mem_to_wb_1, mem_to_id_2}, {hl, hl});
      return;
    end
    last = ad + ((dd == 0) ? 1 : dd);
    for (int c = 0; c <= last; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      stall = (c < last || hold > 0) ? 6'b011111 : 6'b000000;
      ex_to_mem_bus = (c < last) ? {$urandom, $urandom, $urandom, $urandom} : '0;
      ex_to_mem_1 = (c < last) ? {$urandom, $urandom, $urandom} : '0;
      data_sram_addr_ok = (c == ad);
      data_sram_data_ok = (c == ad + dd);
      data_sram_rdata = data_sram_data_ok ? rdv : $urandom;
      #1;
      chk("mem_req", data_sram_req, (c <= ad));
      chk("mem_stallreq", stallreq_for_mem, (c < last));
      if (c <= ad) begin
        chk("mem_addr", data_sram_addr, {res[31:2], 2'b00});
        chk("mem_wr", data_sram_wr, is_st);
        chk("mem_wstrb", data_sram_wstrb, exp_strb);
        if (is_st) chk("mem_wdata", data_sram_wdata, exp_wdata);
      end
      if (c < last) chk("mem_fwd_we_masked", mem_to_id_bus[37], 1'b0);
      else begin
        chk("mem_wb_bus", mem_to_wb_bus, exp_wb);
        chk("mem_id_bus", mem_to_id_bus, {we, wa, exp_wd});
        chk("mem_hilo", {mem_to_wb_1, mem_to_id_2}, {hl, hl});
      end
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      stall = 6'b011111;
      data_sram_addr_ok = 1'b0;
      data_sram_data_ok = 1'b1;
      data_sram_rdata = ~rdv;
      #1;
      chk("done_hold_wb_bus", mem_to_wb_bus, exp_wb);
      chk("done_hold_stallreq", stallreq_for_mem, 1'b0);
      chk("done_hold_req", data_sram_req, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b0;
    stall = 6'b0;
    ex_to_mem_bus = '0;
    ex_to_mem_1 = '0;
    data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata = '0;
    @(posedge clk); @(posedge clk); #2;
    chk("reset_wb_bus", mem_to_wb_bus, 70'b0);
    chk("reset_id_bus", mem_to_id_bus, 38'b0);
    chk("reset_hilo", {mem_to_wb_1, mem_to_id_2}, 132'b0);
    chk("reset_req_stall", {data_sram_req, stallreq_for_mem}, 2'b00);
    @(negedge clk);
    rst = 1'b1;

    // ALU pass-through
    run_txn(0, 32'hBFC00010, 1'b1, 5'd8, 32'h00001234, 32'h0, 32'h0, 66'h0, 0, 0, 0);
    // lb / lbu sign and zero extension, then external stall while DONE
    run_txn(1, 32'hBFC00014, 1'b1, 5'd9, 32'h80000003, 32'h0, 32'h80FF7F01, 66'h1, 0, 1, 2);
    run_txn(2, 32'hBFC00018, 1'b1, 5'd9, 32'h80000003, 32'h0, 32'h80FF7F01, 66'h2, 0, 1, 0);
    // sh store to upper halfword
    run_txn(7, 32'hBFC0001C, 1'b0, 5'd0, 32'h00000102, 32'hAAAA5678, 32'h0, 66'h3, 0, 1, 0);
    // delayed slave: addr_ok after 3 cycles, data_ok 2 later
    run_txn(5, 32'hBFC00020, 1'b1, 5'd10, 32'h00001000, 32'h0, 32'hDEADBEEF, 66'h4, 3, 2, 0);
    // addr_ok and data_ok together
    run_txn(3, 32'hBFC00024, 1'b1, 5'd11, 32'h00002002, 32'h0, 32'h8001_7FFF, 66'h5, 1, 0, 1);

    // reset in WAIT abandons the access, a late data_ok is ignored
    @(negedge clk);
    ex_to_mem_bus = mk_bus(5, 32'hBFC00030, 1'b1, 5'd12, 32'h00000040, 32'h0);
    ex_to_mem_1 = {1'b1, 1'b1, 32'h5, 32'h6};
    stall = 6'b0;
    data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b0;
    @(posedge clk); #1;
    stall = 6'b011111;
    data_sram_addr_ok = 1'b1;
    @(posedge clk); #1;
    data_sram_addr_ok = 1'b0;
    #1;
    chk("wait_stallreq", stallreq_for_mem, 1'b1);
    rst = 1'b0;
    #1;
    chk("rst_mid_req_stall", {data_sram_req, stallreq_for_mem}, 2'b00);
    chk("rst_mid_wb_bus", mem_to_wb_bus, 70'b0);
    chk("rst_mid_hilo", mem_to_wb_1, 66'b0);
    chk("rst_mid_id_bus", mem_to_id_bus, 38'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'hCAFEF00D;
    #1;
    chk("late_dataok_stall", {data_sram_req, stallreq_for_mem}, 2'b00);
    chk("late_dataok_wb_bus", mem_to_wb_bus, 70'b0);
    @(posedge clk); #1;
    data_sram_data_ok = 1'b0;
    #1;
    chk("after_late_wb_bus", mem_to_wb_bus, 70'b0);
    chk("after_late_req", data_sram_req, 1'b0);

    // bubble zeroes the register, then a real capture of HI/LO
    run_txn(0, 32'hBFC00040, 1'b1, 5'd3, 32'h77, 32'h0, 32'h0, {1'b0, 1'b1, 32'h99, 32'h88}, 0, 0, 0);
    @(negedge clk);
    stall = 6'b001000;
    ex_to_mem_1 = {1'b1, 1'b0, 32'h11, 32'h22};
    @(posedge clk); #2;
    chk("bubble_hilo", mem_to_wb_1, 66'b0);
    chk("bubble_wb_bus", mem_to_wb_bus, 70'b0);
    @(negedge clk);
    stall = 6'b000000;
    @(posedge clk); #2;
    chk("hilo_wb_1", mem_to_wb_1, {1'b1, 1'b0, 32'h11, 32'h22});
    chk("hilo_id_2", mem_to_id_2, {1'b1, 1'b0, 32'h11, 32'h22});

    // randomized instruction mix and slave latencies
    for (int n = 0; n < 150; n++) begin
      run_txn($urandom_range(0, 8), $urandom, 1'($urandom), 5'($urandom), $urandom, $urandom,
              $urandom, {$urandom, $urandom, $urandom}, $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
